seg7_scan_capture: RTL and testbench

Receive-side counterpart of the `Top` seven-segment output pair. It samples the multiplexed `out7`/`en_out` lines and debounces each digit pattern. It then decodes the segment glyph back to a hex nibble and reassembles the full 32-bit displayed word. It sits beside `Top` in the bench or on-board self-check path, so displayed values can be compared against expected `Instruction`/register results without reading LEDs.

---
 rtl/seg7_capture_pkg.sv | 43 ++++
 rtl/seg7_glyph_decode.sv | 21 ++
 rtl/seg7_scan_capture.sv | 93 +++++++++
 tb/tb_seg7_scan_capture.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seg7_capture_pkg.sv
// Shared constants for the seven-segment scan capture block: glyph table,
// idle line levels, digit count and the enable-pattern classifier.
package seg7_capture_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_IDLE = 7'h7F;
  localparam logic [7:0] EN_IDLE  = 8'hFF;

  // Active-high gfedcba, entry i is the glyph for hex digit i.
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    EN_BLANK,
    EN_ONE,
    EN_MULTI
  } en_class_e;

  typedef struct packed {
    en_class_e  cls;
    logic [2:0] idx;
  } en_info_t;

  function automatic en_info_t classify_en(input logic [NUM_DIGITS-1:0] en);
    en_info_t    r;
    int unsigned zeros;
    r.idx = '0;
    zeros = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!en[i]) begin
        zeros++;
        r.idx = 3'(i);
      end
    end
    if (zeros == 0)      r.cls = EN_BLANK;
    else if (zeros == 1) r.cls = EN_ONE;
    else                 r.cls = EN_MULTI;
    return r;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-nibble lookup for active-low segment lines.
import seg7_capture_pkg::*;

module seg7_glyph_decode (
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = '0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (~seg == GLYPH[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 7-seg scan, debounces each digit and reassembles the
// 32-bit displayed word. Define SEG7_CAPTURE_CHECK_EN for the sticky Error flag.
import seg7_capture_pkg::*;

module seg7_scan_capture #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [6:0]            out7,
  input  logic [NUM_DIGITS-1:0] en_out,
  output logic [31:0]           Value,
  output logic                  Valid,
  output logic [NUM_DIGITS-1:0] DigitMask,
  output logic                  Error
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [6:0]                  s_seg;
  logic [NUM_DIGITS-1:0]       s_en;
  logic [7:0]                  stab_cnt;
  logic [NUM_DIGITS-1:0][3:0]  slots, slots_next;
  logic [NUM_DIGITS-1:0]       slot_we, mask_next;
  logic [3:0]                  nib;
  logic                        hit;
  logic                        same, capture, frame_done;
  en_info_t                    en_info;

  assign same    = (out7 == s_seg) && (en_out == s_en);
  // Fires only on the counter's step into SETTLE, so a held pattern captures once.
  assign capture = same && (stab_cnt == SETTLE - 8'd1);
  assign en_info = classify_en(s_en);

  seg7_glyph_decode u_dec (
    .seg    (s_seg),
    .nibble (nib),
    .hit    (hit)
  );

  always_comb begin
    slots_next = slots;
    slot_we    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && en_info.cls == EN_ONE && hit && en_info.idx == 3'(i)) begin
        slot_we[i]    = 1'b1;
        slots_next[i] = nib;
      end
    end
  end

  assign mask_next  = DigitMask | slot_we;
  assign frame_done = (|slot_we) && (&mask_next);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s_seg     <= SEG_IDLE;
      s_en      <= EN_IDLE;
      stab_cnt  <= '0;
      slots     <= '0;
      DigitMask <= '0;
      Value     <= '0;
      Valid     <= 1'b0;
    end else begin
      s_seg <= out7;
      s_en  <= en_out;
      if (!same)                 stab_cnt <= '0;
      else if (stab_cnt != SETTLE) stab_cnt <= stab_cnt + 8'd1;
      slots <= slots_next;
      Valid <= frame_done;
      if (frame_done) begin
        Value     <= slots_next;
        DigitMask <= '0;
      end else begin
        DigitMask <= mask_next;
      end
    end
  end

`ifdef SEG7_CAPTURE_CHECK_EN
  logic err_evt;
  assign err_evt = capture &&
                   (en_info.cls == EN_MULTI || (en_info.cls == EN_ONE && !hit));

  always_ff @(posedge Clk) begin
    if (Reset)        Error <= 1'b0;
    else if (err_evt) Error <= 1'b1;
  end
`else
  assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed table-driven bench for seg7_scan_capture with SETTLE_CYCLES=4.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  out7 = 7'h7F;
  logic [7:0]  en_out = 8'hFF;
  logic [31:0] value;
  logic        valid;
  logic [7:0]  mask;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount  = 0;

`ifdef SEG7_CAPTURE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // Active-low pin levels for hex digits 0..F.
  localparam logic [15:0][6:0] PINS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct {
    logic [7:0]  en;
    logic [6:0]  seg;
    int          hold;
    logic [7:0]  exp_mask;
    logic [31:0] exp_value;
  } vec_t;

  vec_t frame[8];

  seg7_scan_capture #(.SETTLE_CYCLES(4)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .out7      (out7),
    .en_out    (en_out),
    .Value     (value),
    .Valid     (valid),
    .DigitMask (mask),
    .Error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) vcount++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pattern is present at the next n rising edges; returns #1 after the last.
  task automatic hold(input logic [7:0] en, input logic [6:0] seg, input int n);
    en_out = en;
    out7   = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    en_out = 8'hFF;
    out7   = 7'h7F;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic dig(input int d, input int nibble, input int n);
    logic [7:0] en;
    en = 8'hFF;
    en[d] = 1'b0;
    hold(en, PINS[nibble], n);
  endtask

  initial begin
    int v0;
    for (int i = 0; i < 8; i++) begin
      frame[i].en        = ~(8'h01 << i);
      frame[i].seg       = PINS[8 - i];
      frame[i].hold      = 8;
      frame[i].exp_mask  = (i == 7) ? 8'h00 : 8'((16'h0002 << i) - 16'h1);
      frame[i].exp_value = (i == 7) ? 32'h12345678 : 32'h0;
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_value", value, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_mask", {24'h0, mask}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    hold(8'hFF, 7'h7F, 6);

    // Full frame from the table.
    v0 = vcount;
    for (int i = 0; i < 8; i++) begin
      hold(frame[i].en, frame[i].seg, frame[i].hold);
      check($sformatf("frame_mask%0d", i), {24'h0, mask}, {24'h0, frame[i].exp_mask});
      check($sformatf("frame_value%0d", i), value, frame[i].exp_value);
    end
    check("frame_valid_pulses", vcount - v0, 1);

    // Glitch rejection: 4 edges not enough, 5 edges captures.
    pulse_reset();
    hold(8'hFE, 7'h40, 4);
    check("glitch_4edges", {31'h0, mask[0]}, 32'h0);
    hold(8'hFF, 7'h7F, 6);
    check("glitch_after_change", {31'h0, mask[0]}, 32'h0);
    hold(8'hFE, 7'h40, 4);
    check("settle_4of5", {31'h0, mask[0]}, 32'h0);
    hold(8'hFE, 7'h40, 1);
    check("settle_5th_edge", {31'h0, mask[0]}, 32'h1);

    // Multi-zero enable.
    pulse_reset();
    hold(8'hFC, 7'h40, 8);
    check("multi_zero_error", {31'h0, error}, {31'h0, EXP_ERR});
    check("multi_zero_mask", {24'h0, mask}, 32'h0);

    // Unrecognised glyph on digit 3 after a legal one there.
    pulse_reset();
    dig(3, 5, 8);
    hold(8'hF7, 7'h7E, 8);
    check("bad_glyph_error", {31'h0, error}, {31'h0, EXP_ERR});
    check("bad_glyph_mask", {24'h0, mask}, 32'h08);
    v0 = vcount;
    for (int d = 0; d < 8; d++) if (d != 3) dig(d, 0, 8);
    check("bad_glyph_slot3", value, 32'h00005000);
    check("bad_glyph_valid", vcount - v0, 1);
    check("error_sticky", {31'h0, error}, {31'h0, EXP_ERR});

    // Overwrite of an already captured digit.
    pulse_reset();
    check("reset_clears_error", {31'h0, error}, 32'h0);
    dig(2, 10, 8);
    dig(2, 15, 8);
    check("overwrite_mask", {24'h0, mask}, 32'h04);
    for (int d = 0; d < 8; d++) if (d != 2) dig(d, 0, 8);
    check("overwrite_value", value, 32'h00000F00);

    // Reset mid-frame.
    for (int d = 0; d < 4; d++) dig(d, d + 1, 8);
    check("mid_mask_before", {24'h0, mask}, 32'h0F);
    pulse_reset();
    check("mid_mask_after_rst", {24'h0, mask}, 32'h0);
    check("mid_value_after_rst", value, 32'h0);
    v0 = vcount;
    for (int d = 4; d < 8; d++) dig(d, d + 1, 8);
    check("mid_no_valid", vcount - v0, 0);
    check("mid_partial_mask", {24'h0, mask}, 32'hF0);
    pulse_reset();
    for (int d = 0; d < 7; d++) dig(d, 15 - d, 8);
    dig(7, 8, 5);
    check("valid_on_capture_edge", {31'h0, valid}, 32'h1);
    check("rescan_value", value, 32'h89ABCDEF);
    check("rescan_mask", {24'h0, mask}, 32'h0);
    hold(8'h7F, PINS[8], 1);
    check("valid_one_cycle", {31'h0, valid}, 32'h0);
    check("rescan_valid_pulses", vcount - v0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
